// File: rtl/shift_2_pkg.sv
// Shared definitions for the edge-detector shift datapath.
package shift_2_pkg;

    localparam int unsigned WORD_WIDTH = 32;

endpackage : shift_2_pkg

// File: rtl/shift_2_if.sv
// Data/enable bundle between a word producer and the two-deep shift register.
interface shift_2_if
    import shift_2_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
);

    logic             write_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] word_1;
    logic [WIDTH-1:0] word_2;

    modport master (
        output write_en,
        output data_in,
        input  data_out,
        input  word_1,
        input  word_2
    );

    modport slave (
        input  write_en,
        input  data_in,
        output data_out,
        output word_1,
        output word_2
    );

endinterface : shift_2_if

// File: rtl/shift_2_stage.sv
// One WIDTH-bit delay stage: synchronous reset wins over the load enable.
module shift_2_stage
    import shift_2_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : shift_2_stage

// File: rtl/shift_2.sv
// Two-deep word delay line; word_1 is the newest word, word_2/data_out the oldest.
module shift_2
    import shift_2_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    shift_2_if.slave bus
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    generate
        if (WIDTH < 1) begin : g_width_check
            $error("shift_2: WIDTH must be at least 1");
        end
    endgenerate

    shift_2_stage #(
        .WIDTH (WIDTH)
    ) u_stage1 (
        .clk (clk),
        .rst (rst),
        .en  (bus.write_en),
        .d   (bus.data_in),
        .q   (stage1_q)
    );

    // Stage 2 shares the enable so both words move together on the same edge.
    shift_2_stage #(
        .WIDTH (WIDTH)
    ) u_stage2 (
        .clk (clk),
        .rst (rst),
        .en  (bus.write_en),
        .d   (stage1_q),
        .q   (stage2_q)
    );

    assign bus.word_1   = stage1_q;
    assign bus.word_2   = stage2_q;
    assign bus.data_out = stage2_q;

endmodule : shift_2

// File: tb/tb_shift_2.sv
// Self-checking bench for shift_2: vector table plus a modelled free-running stream.
module tb_shift_2;

    localparam int unsigned W = 32;

    typedef struct {
        logic         rst;
        logic         we;
        logic [W-1:0] din;
        logic [W-1:0] exp_w1;
        logic [W-1:0] exp_w2;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] exp_w1;
        logic [W-1:0] exp_w2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int n_compared   = 0;
    int n_mismatched = 0;

    exp_t sb[$];
    vec_t vecs[$];

    shift_2_if #(.WIDTH(W)) bus ();

    shift_2 #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then compare 1 ns after the following rising edge.
    task automatic step(input string name, input logic r, input logic we,
                        input logic [W-1:0] din, input logic [W-1:0] e1, input logic [W-1:0] e2);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.write_en = we;
        bus.data_in  = din;
        e.name   = name;
        e.exp_w1 = e1;
        e.exp_w2 = e2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: scoreboard empty, got %h, expected an entry", name, bus.word_1);
        end else begin
            e = sb.pop_front();
            check({e.name, ".word_1"},   bus.word_1,   e.exp_w1);
            check({e.name, ".word_2"},   bus.word_2,   e.exp_w2);
            check({e.name, ".data_out"}, bus.data_out, e.exp_w2);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic [W-1:0] din,
                                input logic [W-1:0] e1, input logic [W-1:0] e2);
        vec_t v;
        v.rst = r; v.we = we; v.din = din; v.exp_w1 = e1; v.exp_w2 = e2;
        return v;
    endfunction

    initial begin
        logic [W-1:0] m1;
        logic [W-1:0] m2;
        logic [W-1:0] cnt;
        logic         we;
        int           xbad;

        rst          = 1'b1;
        bus.write_en = 1'b1;
        bus.data_in  = '0;

        // Reset with write_en high and garbage input
        vecs.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0));
        // Streaming 1..4
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2, 2, 1));
        vecs.push_back(mk(0, 1, 3, 3, 2));
        vecs.push_back(mk(0, 1, 4, 4, 3));
        // Hold: load 5, 6 then three gated edges with 9 on the input
        vecs.push_back(mk(0, 1, 5, 5, 4));
        vecs.push_back(mk(0, 1, 6, 6, 5));
        vecs.push_back(mk(0, 0, 9, 6, 5));
        vecs.push_back(mk(0, 0, 9, 6, 5));
        vecs.push_back(mk(0, 0, 9, 6, 5));
        vecs.push_back(mk(0, 1, 7, 7, 6));
        // Reset priority from 6/5
        vecs.push_back(mk(0, 1, 5, 5, 7));
        vecs.push_back(mk(0, 1, 6, 6, 5));
        vecs.push_back(mk(1, 1, 8, 0, 0));
        vecs.push_back(mk(0, 1, 8, 8, 0));
        // Full width
        vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8));
        vecs.push_back(mk(0, 1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF));
        // Alternating bit patterns
        vecs.push_back(mk(0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000));
        vecs.push_back(mk(0, 1, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5));

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].din,
                 vecs[i].exp_w1, vecs[i].exp_w2);
        end

        // Free run: 500 cycles of 20 ns, incrementing input, enable gated in the tail
        step("fr_reset", 1, 1, 32'h12345678, 0, 0);
        m1   = '0;
        m2   = '0;
        cnt  = 32'h100;
        xbad = 0;
        for (int c = 0; c < 500; c++) begin
            we = (c < 400) ? 1'b1 : 1'($urandom_range(0, 1));
            if (we) begin
                m2 = m1;
                m1 = cnt;
            end
            step("free_run", 0, we, cnt, m1, m2);
            if ($isunknown({bus.word_1, bus.word_2, bus.data_out})) xbad++;
            cnt = cnt + 1;
        end
        check("free_run_no_x", 32'(xbad), 0);

        // Mid-stream reset discards contents, then zeros shift out first
        step("mid_rst",    1, 0, 32'hCAFEF00D, 0, 0);
        step("refill_1",   0, 1, 32'h00000011, 32'h11, 0);
        step("refill_2",   0, 1, 32'h00000022, 32'h22, 32'h11);

        check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_shift_2
